// File: rtl/maze_pkg.sv
// Shared types for the maze solver family: move encoding and the path-player FSM states.
package maze_pkg;

  typedef enum logic [1:0] {
    MoveUp    = 2'd0,
    MoveRight = 2'd1,
    MoveLeft  = 2'd2,
    MoveDown  = 2'd3
  } move_t;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StApply   = 3'd2,
    StPresent = 3'd3,
    StDone    = 3'd4
  } player_state_t;

endpackage

// File: rtl/maze_pos_update.sv
// Combinational next-position: applies one move to (row, column), wrapping modulo the grid
// size, and flags moves that would leave the grid.
module maze_pos_update
  import maze_pkg::*;
#(
  parameter int unsigned GRID_BITS = 4
) (
  input  logic [GRID_BITS-1:0] i_row,
  input  logic [GRID_BITS-1:0] i_column,
  input  logic [1:0]           i_move,
  output logic [GRID_BITS-1:0] o_row,
  output logic [GRID_BITS-1:0] o_column,
  output logic                 o_out_of_bounds
);

  localparam logic [GRID_BITS-1:0] MaxCoord = '1;
  localparam logic [GRID_BITS-1:0] One      = GRID_BITS'(1);

  move_t w_move;
  assign w_move = move_t'(i_move);

  always_comb begin
    o_row           = i_row;
    o_column        = i_column;
    o_out_of_bounds = 1'b0;
    unique case (w_move)
      MoveUp: begin
        o_row           = i_row - One;
        o_out_of_bounds = (i_row == '0);
      end
      MoveDown: begin
        o_row           = i_row + One;
        o_out_of_bounds = (i_row == MaxCoord);
      end
      MoveLeft: begin
        o_column        = i_column - One;
        o_out_of_bounds = (i_column == '0);
      end
      MoveRight: begin
        o_column        = i_column + One;
        o_out_of_bounds = (i_column == MaxCoord);
      end
    endcase
  end

endmodule

// File: rtl/maze_path_player.sv
// Replays the solver's move queue from (0,0), presenting each cell over valid/ready.
// Define MAZE_PATH_PLAYER_BOUNDS_CHECK_EN to reject off-grid moves instead of wrapping.
module maze_path_player
  import maze_pkg::*;
#(
  parameter int unsigned GRID_BITS = 4,
  parameter int unsigned COUNT_W   = 8,
  parameter int unsigned GOAL_ROW  = 15,
  parameter int unsigned GOAL_COL  = 15
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_queue_empty,
  input  logic [1:0]           i_move,
  output logic                 o_deq,
  output logic                 o_step_valid,
  input  logic                 i_step_ready,
  output logic [GRID_BITS-1:0] o_row,
  output logic [GRID_BITS-1:0] o_column,
  output logic [COUNT_W-1:0]   o_step_count,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_at_goal,
  output logic                 o_error
);

  localparam logic [GRID_BITS-1:0] GoalRow  = GRID_BITS'(GOAL_ROW);
  localparam logic [GRID_BITS-1:0] GoalCol  = GRID_BITS'(GOAL_COL);
  localparam logic [COUNT_W-1:0]   CountMax = '1;

  player_state_t          r_state, w_state_next;
  move_t                  r_move, w_move_next;
  logic [GRID_BITS-1:0]   r_row, w_row_next;
  logic [GRID_BITS-1:0]   r_column, w_column_next;
  logic [COUNT_W-1:0]     r_count, w_count_next;
  logic                   r_at_goal, w_at_goal_next;
  logic                   w_error_set;
  logic                   w_error_clr;

  logic [GRID_BITS-1:0]   w_pos_row;
  logic [GRID_BITS-1:0]   w_pos_column;
  logic                   w_pos_oob;
  logic                   w_reject;

  maze_pos_update #(
    .GRID_BITS(GRID_BITS)
  ) u_pos_update (
    .i_row          (r_row),
    .i_column       (r_column),
    .i_move         (r_move),
    .o_row          (w_pos_row),
    .o_column       (w_pos_column),
    .o_out_of_bounds(w_pos_oob)
  );

`ifdef MAZE_PATH_PLAYER_BOUNDS_CHECK_EN
  assign w_reject = w_pos_oob;
`else
  logic w_unused_oob;
  assign w_unused_oob = w_pos_oob;
  assign w_reject     = 1'b0;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_move_next    = r_move;
    w_row_next     = r_row;
    w_column_next  = r_column;
    w_count_next   = r_count;
    w_at_goal_next = r_at_goal;
    w_error_set    = 1'b0;
    w_error_clr    = 1'b0;
    o_deq          = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_next   = StFetch;
          w_row_next     = '0;
          w_column_next  = '0;
          w_count_next   = '0;
          w_at_goal_next = 1'b0;
          w_error_clr    = 1'b1;
        end
      end
      StFetch: begin
        if (i_queue_empty) begin
          w_state_next   = StDone;
          w_at_goal_next = (r_row == GoalRow) && (r_column == GoalCol);
        end else begin
          w_move_next  = move_t'(i_move);
          o_deq        = 1'b1;
          w_state_next = StApply;
        end
      end
      StApply: begin
        if (w_reject) begin
          // Rejected move leaves position and count untouched and ends the replay.
          w_error_set    = 1'b1;
          w_at_goal_next = 1'b0;
          w_state_next   = StDone;
        end else begin
          w_row_next    = w_pos_row;
          w_column_next = w_pos_column;
          if (r_count != CountMax) begin
            w_count_next = r_count + COUNT_W'(1);
          end
          w_state_next = StPresent;
        end
      end
      StPresent: begin
        if (i_step_ready) begin
          w_state_next = StFetch;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= StIdle;
      r_move    <= MoveUp;
      r_row     <= '0;
      r_column  <= '0;
      r_count   <= '0;
      r_at_goal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_move    <= w_move_next;
      r_row     <= w_row_next;
      r_column  <= w_column_next;
      r_count   <= w_count_next;
      r_at_goal <= w_at_goal_next;
    end
  end

`ifdef MAZE_PATH_PLAYER_BOUNDS_CHECK_EN
  logic r_error;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_error <= 1'b0;
    end else if (w_error_clr) begin
      r_error <= 1'b0;
    end else if (w_error_set) begin
      r_error <= 1'b1;
    end
  end

  assign o_error = r_error;
`else
  logic w_unused_err;
  assign w_unused_err = w_error_set | w_error_clr;
  assign o_error      = 1'b0;
`endif

  assign o_step_valid = (r_state == StPresent);
  assign o_busy       = (r_state == StFetch) || (r_state == StApply) || (r_state == StPresent);
  assign o_done       = (r_state == StDone);
  assign o_at_goal    = r_at_goal;
  assign o_row        = r_row;
  assign o_column     = r_column;
  assign o_step_count = r_count;

endmodule

// File: tb/tb_maze_path_player.sv
// Scoreboard bench for maze_path_player: a queue model feeds moves, a monitor checks each
// accepted step against expected cells pushed by the stimulus.
module tb_maze_path_player;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       q_empty;
  logic [1:0] q_head;
  logic       deq;
  logic       step_valid;
  logic       step_ready;
  logic [3:0] row;
  logic [3:0] column;
  logic [7:0] step_count;
  logic       busy;
  logic       done;
  logic       at_goal;
  logic       error;

  localparam logic [1:0] UP = 2'd0, RIGHT = 2'd1, LEFT = 2'd2, DOWN = 2'd3;

  int n_cmp = 0;
  int n_err = 0;
  int deq_cnt = 0;
  int valid_cnt = 0;

  logic [1:0]  mq[$];
  logic [15:0] exp_q[$];

  maze_path_player dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_start      (start),
    .i_queue_empty(q_empty),
    .i_move       (q_head),
    .o_deq        (deq),
    .o_step_valid (step_valid),
    .i_step_ready (step_ready),
    .o_row        (row),
    .o_column     (column),
    .o_step_count (step_count),
    .o_busy       (busy),
    .o_done       (done),
    .o_at_goal    (at_goal),
    .o_error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Move queue model: pops on deq, presents head just after each edge.
  always @(posedge clk) begin
    if (rst_n && deq) begin
      if (mq.size() > 0) void'(mq.pop_front());
      deq_cnt++;
    end
    #1;
    q_empty = (mq.size() == 0);
    q_head  = (mq.size() > 0) ? mq[0] : 2'd0;
  end

  // Monitor: every accepted step is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && step_valid) begin
      valid_cnt++;
      if (step_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", {16'd0, row, column, step_count}, 32'hFFFF_FFFF);
        end else begin
          check("step", {16'd0, row, column, step_count}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_move(input logic [1:0] m, input int r, input int c, input int n);
    mq.push_back(m);
    exp_q.push_back({r[3:0], c[3:0], n[7:0]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (done) return;
      tick();
    end
    n_cmp++;
    n_err++;
    $display("FAIL done_timeout: got done=0 after %0d cycles, expected done=1", max_cyc);
  endtask

  task automatic wait_step(input int cnt, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (step_valid && step_count == 8'(cnt)) return;
      tick();
    end
    n_cmp++;
    n_err++;
    $display("FAIL step_timeout: step %0d not presented in %0d cycles", cnt, max_cyc);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    step_ready = 1'b1;
    q_empty    = 1'b1;
    q_head     = 2'd0;
    tick();
    tick();

    // Reset state.
    check("rst_outputs", {deq, step_valid, busy, done, at_goal, error}, 0);
    check("rst_pos", {row, column, step_count}, 0);
    rst_n = 1'b1;
    tick();

    // Full path to goal: RIGHT x15 then DOWN x15.
    deq_cnt = 0;
    for (int k = 1; k <= 15; k++) push_move(RIGHT, 0, k, k);
    for (int k = 1; k <= 15; k++) push_move(DOWN, k, 15, 15 + k);
    tick();
    pulse_start();
    check("t1_busy", busy, 1);
    wait_done(200);
    check("t1_done", done, 1);
    check("t1_at_goal", at_goal, 1);
    check("t1_final", {row, column, step_count}, {4'd15, 4'd15, 8'd30});
    check("t1_deq_cnt", deq_cnt, 30);
    check("t1_busy_end", busy, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // Empty path: done two cycles after start.
    deq_cnt   = 0;
    valid_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_not_done_yet", {busy, done}, 2'b10);
    tick();
    check("t2_done", done, 1);
    check("t2_at_goal", at_goal, 0);
    check("t2_count", step_count, 0);
    check("t2_no_deq", deq_cnt, 0);
    check("t2_no_valid", valid_cnt, 0);

    // Back-pressure: DOWN, RIGHT with consumer stalled on step 1.
    deq_cnt    = 0;
    step_ready = 1'b0;
    push_move(DOWN, 1, 0, 1);
    push_move(RIGHT, 1, 1, 2);
    tick();
    pulse_start();
    wait_step(1, 20);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold", {step_valid, row, column, step_count}, {1'b1, 4'd1, 4'd0, 8'd1});
      check("t3_one_deq", deq_cnt, 1);
      tick();
    end
    step_ready = 1'b1;
    wait_done(40);
    check("t3_final", {row, column, step_count}, {4'd1, 4'd1, 8'd2});
    check("t3_deq_cnt", deq_cnt, 2);
    check("t3_sb_empty", exp_q.size(), 0);

    // UP from the origin.
`ifdef MAZE_PATH_PLAYER_BOUNDS_CHECK_EN
    mq.push_back(UP);
    tick();
    pulse_start();
    wait_done(20);
    check("t4_error", {done, error, at_goal}, 3'b110);
    check("t4_pos", {row, column, step_count}, 0);
`else
    push_move(UP, 15, 0, 1);
    tick();
    pulse_start();
    wait_done(20);
    check("t4_error", {done, error, at_goal}, 3'b100);
    check("t4_pos", {row, column, step_count}, {4'd15, 4'd0, 8'd1});
`endif
    check("t4_sb_empty", exp_q.size(), 0);

    // Asynchronous reset while step 3 is presented.
    for (int k = 1; k <= 5; k++) mq.push_back(RIGHT);
    exp_q.push_back({4'd0, 4'd1, 8'd1});
    exp_q.push_back({4'd0, 4'd2, 8'd2});
    tick();
    pulse_start();
    wait_step(3, 30);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_outputs", {deq, step_valid, busy, done, at_goal, error}, 0);
    check("t5_rst_pos", {row, column, step_count}, 0);
    check("t5_sb_empty", exp_q.size(), 0);
    mq.delete();
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    wait_done(10);
    check("t5_clean_done", {done, at_goal, error, step_count}, {3'b100, 8'd0});

    // start while busy is ignored.
    for (int k = 1; k <= 4; k++) push_move(RIGHT, 0, k, k);
    tick();
    pulse_start();
    wait_step(2, 20);
    pulse_start();
    wait_done(40);
    check("t6_final", {row, column, step_count}, {4'd0, 4'd4, 8'd4});
    check("t6_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/maze_path_player.md
Name: maze_path_player

Overview:
- Downstream consumer of the maze solver's move queue: after a solve, drains the recorded moves one per handshake and replays the path from (0,0).
- Presents each resulting cell (row, column, step index) to a display/checker consumer over a valid/ready handshake.
- Reports whether the replayed path ends on the goal cell.

Parameters:
- GRID_BITS, 4, width of row/column coordinate (grid is 2^GRID_BITS square)
- COUNT_W, 8, width of step counter (max 255 replayed moves)
- GOAL_ROW, 15, goal row coordinate
- GOAL_COL, 15, goal column coordinate

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse: begin replay; sampled only in IDLE or DONE
- queue_empty  in  1  high when the move queue holds no moves
- move  in  2  head-of-queue move, valid when queue_empty=0 (0=UP, 1=RIGHT, 2=LEFT, 3=DOWN)
- deq  out  1  one-cycle pop request to the queue
- step_valid  out  1  current step is presented
- step_ready  in  1  consumer accepts the step
- row  out  GRID_BITS  current row
- column  out  GRID_BITS  current column
- step_count  out  COUNT_W  number of moves applied
- busy  out  1  replay in progress
- done  out  1  replay finished; held until next start
- at_goal  out  1  valid with done: final cell equals (GOAL_ROW, GOAL_COL)
- error  out  1  out-of-grid move detected (optional feature only; else tied 0)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; deq, step_valid, busy, done, at_goal, error = 0; row, column, step_count = 0.
- FSM states: IDLE, FETCH, APPLY, PRESENT, DONE.
- IDLE/DONE, start=1 → FETCH next cycle. On that edge: row=column=step_count=0, done=at_goal=error=0, busy=1.
- FETCH:
  - queue_empty=1 → DONE.
  - Otherwise latch move into an internal register, assert deq for exactly this cycle, → APPLY.
  - deq is never high outside FETCH.
- APPLY, one cycle, using the latched move:
  - UP: row-1; DOWN: row+1; LEFT: column-1; RIGHT: column+1.
  - step_count+1, saturating at 2^COUNT_W-1.
  - → PRESENT.
- PRESENT:
  - step_valid=1; row, column and step_count are held stable while step_valid=1 and step_ready=0.
  - Transfer occurs on a cycle with step_valid=1 and step_ready=1 → FETCH. step_valid drops the next cycle unless re-presented.
- Latency: minimum 3 cycles per move (FETCH, APPLY, PRESENT with step_ready=1).
- DONE:
  - busy=0, done=1.
  - at_goal = (row==GOAL_ROW && column==GOAL_COL), registered on entry.
  - The empty path (queue empty at first FETCH) gives done=1, at_goal=0 unless the goal is (0,0).
- start while busy: ignored.
- start and reset asserted together: reset wins.
- Reset mid-replay: everything returns to reset values; the queue is not re-primed by this block.
- Coordinates: arithmetic is GRID_BITS wide, modulo 2^GRID_BITS, unless the optional feature is enabled.

Optional Feature:
- Macro: MAZE_PATH_PLAYER_BOUNDS_CHECK_EN.
- Defined:
  - In APPLY, a move leaving the grid (UP at row 0, DOWN at max row, LEFT at column 0, RIGHT at max column) is not applied; error=1; state → DONE with at_goal=0.
  - error holds until the next start or reset. step_count is not incremented for the rejected move.
- Undefined: coordinates wrap modulo 2^GRID_BITS; error is constant 0.

Decomposition:
- Shared package maze_pkg: move_t enum (UP=0, RIGHT=1, LEFT=2, DOWN=3) and the player state enum.
  - maze_pkg is also used by the stack, queue and datapath.
- Natural sub-module: maze_pos_update, a combinational next-position function taking row, column and move, returning new row, new column and out_of_bounds.

Test Plan:
- Queue RIGHT×15 then DOWN×15, step_ready=1 → 30 steps, last step row=15 col=15 step_count=30; done=1, at_goal=1; deq pulsed exactly 30 times.
- Queue empty at start → done=1 two cycles after start, at_goal=0, step_count=0, no deq, no step_valid.
- Moves DOWN, RIGHT with step_ready held 0 for 5 cycles on step 1 → row=1 col=0 stable for all 5 cycles, no second deq until accept.
- Move UP from (0,0): without the macro → row=15, step_count=1, error=0; with the macro → error=1, done=1, row=0, step_count=0.
- Async reset pulled low during PRESENT of step 3 → all outputs 0 immediately; a following start with empty queue → clean done.
- start pulsed again while busy at step 2 → ignored; replay completes with the correct final count.
